// File: rtl/vending_pkg.sv
// vending_pkg: coin codes, coin values and payout FSM state encoding
package vending_pkg;
  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;
  localparam logic [8:0] VAL_NICKEL   = 9'd5;
  localparam logic [8:0] VAL_DIME     = 9'd10;
  localparam logic [8:0] VAL_QUARTER  = 9'd25;
  typedef enum logic [1:0] {IDLE, SELECT, WAIT, DONE} state_e;
endpackage

// File: rtl/coin_select.sv
// coin_select: picks the largest coin that fits the balance and is in stock
module coin_select
  import vending_pkg::*;
#(
  parameter int TUBE_W = 6
) (
  input  logic [8:0]        bal,
  input  logic [TUBE_W-1:0] q_level,
  input  logic [TUBE_W-1:0] d_level,
  input  logic [TUBE_W-1:0] n_level,
  output logic              found,
  output logic [1:0]        code,
  output logic [8:0]        value
);
  logic q_ok, d_ok, n_ok;
  // greedy priority: quarter, then dime, then nickel
  always_comb begin
    q_ok  = bal >= VAL_QUARTER && q_level != '0;
    d_ok  = bal >= VAL_DIME && d_level != '0;
    n_ok  = bal >= VAL_NICKEL && n_level != '0;
    found = q_ok | d_ok | n_ok;
    code  = q_ok ? COIN_QUARTER : d_ok ? COIN_DIME : n_ok ? COIN_NICKEL : COIN_NONE;
    value = q_ok ? VAL_QUARTER : d_ok ? VAL_DIME : n_ok ? VAL_NICKEL : 9'd0;
  end
endmodule

// File: rtl/coin_payout.sv
// coin_payout: greedy coin-by-coin change payout over a hopper req/ack handshake
module coin_payout
  import vending_pkg::*;
#(
  parameter int TUBE_W      = 6,
  parameter int INIT_Q      = 20,
  parameter int INIT_D      = 20,
  parameter int INIT_N      = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        amount,
  input  logic              refill,
  output logic [1:0]        eject,
  output logic              eject_req,
  input  logic              eject_ack,
  output logic              busy,
  output logic              done,
  output logic [8:0]        remainder,
  output logic              fault,
  output logic [TUBE_W-1:0] q_level,
  output logic [TUBE_W-1:0] d_level,
  output logic [TUBE_W-1:0] n_level
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TUBE_W-1:0] TUBE_MAX = '1;
  state_e            state_q;
  logic [8:0]        bal_q, bal_d, val_q, rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        eject_q;
  logic              req_q, busy_q, done_q, fault_q;
  logic [TUBE_W-1:0] q_level_q, d_level_q, n_level_q;
  logic              sel_found;
  logic [1:0]        sel_code;
  logic [8:0]        sel_value;
  coin_select #(.TUBE_W(TUBE_W)) u_sel (
    .bal    (bal_q),
    .q_level(q_level_q),
    .d_level(d_level_q),
    .n_level(n_level_q),
    .found  (sel_found),
    .code   (sel_code),
    .value  (sel_value)
  );
  // balance after the coin currently offered to the hopper is accepted
  always_comb bal_d = bal_q - val_q;
  // payout FSM with registered handshake, status and tube levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bal_q     <= '0;
      val_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      eject_q   <= COIN_NONE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      q_level_q <= TUBE_W'(INIT_Q);
      d_level_q <= TUBE_W'(INIT_D);
      n_level_q <= TUBE_W'(INIT_N);
    end else begin
      case (state_q)
        IDLE: begin
          if (refill) begin
            q_level_q <= TUBE_MAX;
            d_level_q <= TUBE_MAX;
            n_level_q <= TUBE_MAX;
          end else if (start) begin
            bal_q   <= amount;
            fault_q <= 1'b0;
            rem_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            eject_q <= sel_code;
            val_q   <= sel_value;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            rem_q   <= bal_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WAIT: begin
          if (eject_ack) begin
            bal_q     <= bal_d;
            q_level_q <= q_level_q - TUBE_W'(eject_q == COIN_QUARTER);
            d_level_q <= d_level_q - TUBE_W'(eject_q == COIN_DIME);
            n_level_q <= n_level_q - TUBE_W'(eject_q == COIN_NICKEL);
            eject_q   <= COIN_NONE;
            req_q     <= 1'b0;
            state_q   <= SELECT;
          end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            fault_q <= 1'b1;
            rem_q   <= bal_q;
            eject_q <= COIN_NONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign eject     = eject_q;
  assign eject_req = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remainder = rem_q;
  assign fault     = fault_q;
  assign q_level   = q_level_q;
  assign d_level   = d_level_q;
  assign n_level   = n_level_q;
endmodule

// File: tb/tb_coin_payout.sv
// tb_coin_payout: directed checks of greedy payout, timeout, refill and reset abort
module tb_coin_payout;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, refill = 1'b0, eject_ack = 1'b0;
  logic [8:0] amount = '0;
  logic [1:0] eject;
  logic       eject_req, busy, done, fault;
  logic [8:0] remainder;
  logic [5:0] q_level, d_level, n_level;
  int         checks = 0, errors = 0;
  longint     seq;
  int         ncoins, done_at, req_cycles, nreq, done_hits;
  coin_payout dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .amount   (amount),
    .refill   (refill),
    .eject    (eject),
    .eject_req(eject_req),
    .eject_ack(eject_ack),
    .busy     (busy),
    .done     (done),
    .remainder(remainder),
    .fault    (fault),
    .q_level  (q_level),
    .d_level  (d_level),
    .n_level  (n_level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic pay(input logic [8:0] amt, input bit ack_en, input bit poke);
    seq = 0;
    ncoins = 0;
    done_at = -1;
    req_cycles = 0;
    start = 1'b1;
    amount = amt;
    @(negedge clk);
    start = 1'b0;
    amount = '0;
    for (int cyc = 0; cyc < 300 && done_at < 0; cyc++) begin
      if (cyc == 0) chk("busy_on", busy, 1);
      if (done) done_at = cyc;
      if (eject_req) req_cycles++;
      if (eject_req && ack_en && !eject_ack) begin
        seq = (seq << 2) | longint'(eject);
        ncoins++;
        eject_ack = 1'b1;
      end else eject_ack = 1'b0;
      start  = poke && cyc == 2;
      refill = poke && cyc == 2;
      amount = (poke && cyc == 2) ? 9'd10 : 9'd0;
      @(negedge clk);
    end
    eject_ack = 1'b0;
    start = 1'b0;
    refill = 1'b0;
    chk("done_seen", done_at >= 0, 1);
    chk("done_single", done, 0);
    chk("busy_off", busy, 0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_eject", eject, 0);
    chk("rst_req", eject_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_levels", {q_level, d_level, n_level}, {6'd20, 6'd20, 6'd20});
    rst_n = 1'b1;
    @(negedge clk);
    pay(9'd65, 1'b1, 1'b0);
    chk("p65_seq", seq, 'hF9);
    chk("p65_n", ncoins, 4);
    chk("p65_rem", remainder, 0);
    chk("p65_fault", fault, 0);
    chk("p65_levels", {q_level, d_level, n_level}, {6'd18, 6'd19, 6'd19});
    pay(9'd0, 1'b1, 1'b0);
    chk("p0_done_at", done_at, 1);
    chk("p0_n", ncoins, 0);
    chk("p0_rem", remainder, 0);
    do_reset();
    pay(9'd32, 1'b1, 1'b0);
    chk("p32_seq", seq, 'hD);
    chk("p32_rem", remainder, 2);
    chk("p32_fault", fault, 0);
    do_reset();
    pay(9'd25, 1'b0, 1'b0);
    chk("to_fault", fault, 1);
    chk("to_rem", remainder, 25);
    chk("to_q", q_level, 20);
    chk("to_req_cycles", req_cycles, 15);
    chk("to_done_at", done_at, 16);
    chk("to_req_off", eject_req, 0);
    pay(9'd5, 1'b1, 1'b0);
    chk("clr_fault", fault, 0);
    chk("clr_seq", seq, 1);
    chk("clr_rem", remainder, 0);
    do_reset();
    pay(9'd500, 1'b1, 1'b0);
    chk("p500_n", ncoins, 20);
    chk("p500_q", q_level, 0);
    chk("p500_rem", remainder, 0);
    pay(9'd50, 1'b1, 1'b0);
    chk("p50_seq", seq, 'h2AA);
    chk("p50_d", d_level, 15);
    chk("p50_rem", remainder, 0);
    do_reset();
    pay(9'd65, 1'b1, 1'b1);
    chk("poke_seq", seq, 'hF9);
    chk("poke_rem", remainder, 0);
    chk("poke_levels", {q_level, d_level, n_level}, {6'd18, 6'd19, 6'd19});
    refill = 1'b1;
    start = 1'b1;
    amount = 9'd10;
    @(negedge clk);
    refill = 1'b0;
    start = 1'b0;
    amount = '0;
    chk("refill_start_ign", busy, 0);
    chk("refill_levels", {q_level, d_level, n_level}, {6'd63, 6'd63, 6'd63});
    do_reset();
    start = 1'b1;
    amount = 9'd65;
    @(negedge clk);
    start = 1'b0;
    nreq = 0;
    for (int cyc = 0; cyc < 50 && nreq < 2; cyc++) begin
      if (eject_req && !eject_ack) begin
        nreq++;
        eject_ack = nreq < 2;
      end else eject_ack = 1'b0;
      if (nreq < 2) @(negedge clk);
    end
    eject_ack = 1'b0;
    chk("mid_req_seen", nreq, 2);
    chk("mid_q_before", q_level, 19);
    rst_n = 1'b0;
    #1;
    chk("mid_req_drop", eject_req, 0);
    chk("mid_busy", busy, 0);
    done_hits = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    chk("mid_no_done", done_hits, 0);
    chk("mid_levels", {q_level, d_level, n_level}, {6'd20, 6'd20, 6'd20});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/coin_payout.md
Name: coin_payout

Overview:
- Sequential change payout engine: takes a cents amount and ejects physical coins one at a time to the coin hopper over a req/ack handshake.
- Sits between the vending controller's cancel/change path and the hopper driver.
- Replaces the one-shot combinational coin split with greedy payout limited by tube inventory.
- Tracks quarter, dime and nickel tube levels and reports any unpaid remainder.

Parameters:
- TUBE_W, 6, width of each tube level counter; TUBE_MAX = 2^TUBE_W-1.
- INIT_Q, 20, quarter tube level after reset.
- INIT_D, 20, dime tube level after reset.
- INIT_N, 20, nickel tube level after reset.
- ACK_TIMEOUT, 15, cycles in WAIT without eject_ack before fault.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  payout request, sampled in IDLE only.
- amount  in  9  cents to pay, 0..511, latched on accepted start.
- refill  in  1  set all tubes to TUBE_MAX, honoured in IDLE only.
- eject  out  2  coin code: 00 none, 01 nickel, 10 dime, 11 quarter; valid while eject_req=1, else 00.
- eject_req  out  1  hopper request.
- eject_ack  in  1  hopper accepted coin.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle completion pulse.
- remainder  out  9  unpaid cents; valid from done, held until the next accepted start.
- fault  out  1  sticky hopper timeout flag; cleared on the next accepted start.
- q_level, d_level, n_level  out  TUBE_W each  current tube levels.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - eject=00; eject_req, busy, done, fault = 0; remainder=0.
  - Levels = INIT_Q / INIT_D / INIT_N; internal balance bal=0; timeout counter=0.
- IDLE:
  - refill=1 sets all levels to TUBE_MAX and takes priority; start in the same cycle is ignored.
  - Otherwise start=1 latches bal=amount, clears fault and remainder, and goes to SELECT.
- SELECT (1 cycle):
  - Picks the largest coin c in {25,10,5} with c<=bal and level(c)!=0.
  - If one is found, go to WAIT; the next cycle drives eject=code(c) and eject_req=1.
  - If none is found, remainder=bal and go to DONE.
- WAIT:
  - eject and eject_req are held stable until eject_ack=1 is sampled.
  - On that cycle: bal -= c and level(c) -= 1. The next cycle drops eject_req, sets eject=00 and returns to SELECT.
  - Minimum cost per coin is 2 cycles (SELECT + ack cycle).
  - eject_ack while eject_req=0 is ignored.
- Timeout: the counter increments each WAIT cycle without ack and resets on entering WAIT. On reaching ACK_TIMEOUT: fault=1, remainder=bal, no tube decrement, drop req, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 the following cycle, then IDLE.
- Arithmetic:
  - bal is 9 bits and never underflows, because c<=bal is checked before selection.
  - Levels never underflow, because level!=0 is checked.
  - amount not a multiple of 5 leaves a remainder of 1..4 (or more if tubes run short).
- Boundary cases:
  - amount=0 → done 2 cycles after start, remainder 0.
  - start or refill while busy: ignored, no effect on the payout in progress.
  - rst_n low mid-payout: immediate abort, no done pulse, levels return to INIT values.

Decomposition:
- vending_pkg holds:
  - coin code constants COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER;
  - value constants 5, 10, 25;
  - the state encoding IDLE, SELECT, WAIT, DONE.
- One combinational sub-module, coin_select: inputs bal and three levels; outputs found, code and value. It is reused by any future change logic.

Test Plan:
- Reset, amount=65, ack 1 cycle after each req → ejects 11,11,10,01; done; remainder=0; q/d/n=18/19/19.
- INIT_Q=0, amount=50 → five dime ejects; remainder=0; d_level=15.
- amount=32 → ejects 11 then 01; remainder=2; fault=0.
- amount=25, eject_ack held 0 → fault=1 after 15 WAIT cycles; remainder=25; q_level unchanged at 20; done pulses once.
- Mid-payout start(amount=10) and refill=1 ignored; then in IDLE refill=1 → all levels=63.
- rst_n low during WAIT of the second coin of 65 → eject_req=0 immediately; no done; levels=20/20/20.
